// File: rtl/sub_disp_pkg.sv
// Shared types and constants for the subtractor result display.
// The build macro SUB_DISP_ACTIVE_LOW_EN only affects the top-level output register.
package sub_disp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_e;

  // Scan slot order: ones, tens, sign.
  localparam logic [1:0] DIG_ONES = 2'd0;
  localparam logic [1:0] DIG_TENS = 2'd1;
  localparam logic [1:0] DIG_SIGN = 2'd2;

  // Segment bit order is {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Digit enable for a slot index; index 3 is never reached and yields 000.
  function automatic logic [2:0] dig_onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

endpackage

// File: rtl/sub_disp_seg7_dec.sv
// Combinational BCD to 7-segment decoder. Codes 10..15 show blank.
module seg7_dec
  import sub_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Lookup of the segment pattern for one decimal digit.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = 7'h3F;
      4'd1:    o_seg = 7'h06;
      4'd2:    o_seg = 7'h5B;
      4'd3:    o_seg = 7'h4F;
      4'd4:    o_seg = 7'h66;
      4'd5:    o_seg = 7'h6D;
      4'd6:    o_seg = 7'h7D;
      4'd7:    o_seg = 7'h07;
      4'd8:    o_seg = 7'h7F;
      4'd9:    o_seg = 7'h6F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sub_disp.sv
// Display stage for the 4-bit subtractor result: captures sign and magnitude,
// splits the magnitude into tens/ones and scans a 3-digit 7-segment display
// (sign, tens, ones). Dashes are shown until a result has been captured.
// Define SUB_DISP_ACTIVE_LOW_EN for common-anode boards (seg/an inverted).
module sub_disp
  import sub_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int MAG_W    = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             valid,
  input  logic             clear,
  input  logic             buho,
  input  logic [MAG_W-1:0] mag,
  output logic [6:0]       seg,
  output logic [2:0]       an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

`ifdef SUB_DISP_ACTIVE_LOW_EN
  localparam logic [6:0] SEG_XOR = 7'h7F;
  localparam logic [2:0] AN_XOR  = 3'b111;
`else
  localparam logic [6:0] SEG_XOR = 7'h00;
  localparam logic [2:0] AN_XOR  = 3'b000;
`endif

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_cap_buho;
  logic [MAG_W-1:0] r_cap_mag;
  logic             r_tens;
  logic [3:0]       r_ones;
  logic [PW-1:0]    r_presc;
  logic [1:0]       r_idx;
  logic [6:0]       r_seg;
  logic [2:0]       r_an;

  logic             w_cap;
  logic             w_tens_bit;
  logic             w_wrap;
  logic [3:0]       w_bcd;
  logic [6:0]       w_dec;
  logic [6:0]       w_pat;

  // clear dominates valid: nothing is captured on a cycle that clears.
  assign w_cap      = valid & ~clear;
  assign w_tens_bit = (r_cap_mag >= MAG_W'(10));
  assign w_wrap     = (r_presc == PMAX);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: clear returns to dashes, an accepted capture shows the result.
  always_comb begin
    w_state_nxt = r_state;
    if (clear)      w_state_nxt = IDLE;
    else if (valid) w_state_nxt = SHOW;
  end

  // Capture of the incoming result; held while valid is low.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cap_buho <= 1'b0;
      r_cap_mag  <= '0;
    end else if (w_cap) begin
      r_cap_buho <= buho;
      r_cap_mag  <= mag;
    end
  end

  // Binary to two-digit decimal; the magnitude never exceeds 15.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_tens <= 1'b0;
      r_ones <= 4'd0;
    end else begin
      r_tens <= w_tens_bit;
      r_ones <= 4'(r_cap_mag - (w_tens_bit ? MAG_W'(10) : MAG_W'(0)));
    end
  end

  // Free-running scan: prescaler wraps every SCAN_DIV clocks and steps the slot.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_presc <= '0;
      r_idx   <= DIG_ONES;
    end else if (w_wrap) begin
      r_presc <= '0;
      r_idx   <= (r_idx == DIG_SIGN) ? DIG_ONES : r_idx + 2'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // One shared decoder; only the tens slot needs the tens value.
  assign w_bcd = (r_idx == DIG_TENS) ? {3'b000, r_tens} : r_ones;

  seg7_dec u_dec (
    .i_bcd (w_bcd),
    .o_seg (w_dec)
  );

  // Pattern for the active slot: dashes when idle, otherwise the result with
  // leading-zero blanking and no minus sign on a zero magnitude.
  always_comb begin
    w_pat = SEG_BLANK;
    if (r_state == IDLE) begin
      w_pat = SEG_DASH;
    end else begin
      case (r_idx)
        DIG_ONES: w_pat = w_dec;
        DIG_TENS: w_pat = r_tens ? w_dec : SEG_BLANK;
        DIG_SIGN: w_pat = (r_cap_buho && (r_cap_mag != '0)) ? SEG_DASH : SEG_BLANK;
        default:  w_pat = SEG_BLANK;
      endcase
    end
  end

  // Output register; polarity is applied here so the rest of the logic is shared.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_seg <= SEG_XOR;
      r_an  <= AN_XOR;
    end else begin
      r_seg <= w_pat ^ SEG_XOR;
      r_an  <= dig_onehot(r_idx) ^ AN_XOR;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_sub_disp.sv
// Bench for sub_disp with SCAN_DIV = 4. Stimulus pushes the expected pattern
// per digit slot; a monitor matches each slot as the display scans to it.
module tb_sub_disp;

`ifdef SUB_DISP_ACTIVE_LOW_EN
  localparam logic [6:0] SX = 7'h7F;
  localparam logic [2:0] AX = 3'b111;
`else
  localparam logic [6:0] SX = 7'h00;
  localparam logic [2:0] AX = 3'b000;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       valid = 1'b0;
  logic       clear = 1'b0;
  logic       buho = 1'b0;
  logic [3:0] mag = 4'd0;
  logic [6:0] seg;
  logic [2:0] an;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0] an;
    logic [6:0] seg;
    string      name;
  } exp_t;

  exp_t q[$];

  sub_disp #(.SCAN_DIV(4), .MAG_W(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .valid (valid),
    .clear (clear),
    .buho  (buho),
    .mag   (mag),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  // Monitor: whenever the display enables a slot that has a pending expectation,
  // compare it and retire that entry.
  always @(negedge clk) begin
    if (n_rst && q.size() > 0) begin
      logic [2:0] a_act;
      logic [6:0] s_act;
      int hit;
      a_act = an ^ AX;
      s_act = seg ^ SX;
      hit = -1;
      for (int i = 0; i < q.size(); i++)
        if (hit < 0 && q[i].an == a_act) hit = i;
      if (hit >= 0) begin
        total++;
        if (s_act !== q[hit].seg) begin
          bad++;
          $display("FAIL %s an=%b seg got %h want %h", q[hit].name, a_act, s_act, q[hit].seg);
        end
        q.delete(hit);
      end
    end
  end

  task automatic expect3(input logic [6:0] s, input logic [6:0] t, input logic [6:0] o,
                         input string name);
    exp_t e;
    e.name = {name, "_sign"}; e.an = 3'b100; e.seg = s; q.push_back(e);
    e.name = {name, "_tens"}; e.an = 3'b010; e.seg = t; q.push_back(e);
    e.name = {name, "_ones"}; e.an = 3'b001; e.seg = o; q.push_back(e);
  endtask

  // Wait for the monitor to retire everything, bounded by a cycle budget.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s timeout pending=%0d", name, q.size());
      q.delete();
    end
  endtask

  task automatic send(input logic b, input logic [3:0] m);
    @(negedge clk);
    valid = 1'b1; buho = b; mag = m;
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_out", {1'b0, an, seg}, {1'b0, AX, SX});

    // Idle scan timing: each slot lasts 4 clocks, dashes throughout
    n_rst = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      logic [2:0] a_want;
      @(posedge clk); #1;
      a_want = 3'b001 << (((k - 1) / 4) % 3);
      chk($sformatf("idle_an_%0d", k), {1'b0, an ^ AX, 7'h00}, {1'b0, a_want, 7'h00});
      chk($sformatf("idle_seg_%0d", k), {3'b000, seg ^ SX}, {3'b000, 7'h40});
    end
    expect3(7'h40, 7'h40, 7'h40, "idle");
    drain("idle");

    send(1'b1, 4'd6);
    expect3(7'h40, 7'h00, 7'h7D, "neg6");
    drain("neg6");

    send(1'b0, 4'd12);
    expect3(7'h00, 7'h06, 7'h5B, "pos12");
    drain("pos12");

    send(1'b1, 4'd0);
    expect3(7'h00, 7'h00, 7'h3F, "negzero");
    drain("negzero");

    send(1'b1, 4'd15);
    expect3(7'h40, 7'h06, 7'h6D, "neg15");
    drain("neg15");

    send(1'b0, 4'd10);
    expect3(7'h00, 7'h06, 7'h3F, "pos10");
    drain("pos10");

    // clear and valid together: clear wins
    @(negedge clk);
    clear = 1'b1; valid = 1'b1; buho = 1'b0; mag = 4'd9;
    @(negedge clk);
    clear = 1'b0; valid = 1'b0;
    repeat (3) @(negedge clk);
    expect3(7'h40, 7'h40, 7'h40, "clr_and_vld");
    drain("clr_and_vld");

    send(1'b0, 4'd9);
    expect3(7'h00, 7'h00, 7'h6F, "pos9");
    drain("pos9");

    send(1'b1, 4'd3);
    expect3(7'h40, 7'h00, 7'h4F, "neg3");
    drain("neg3");

    // clear alone
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    repeat (3) @(negedge clk);
    expect3(7'h40, 7'h40, 7'h40, "clear");
    drain("clear");

    // Reset mid-slot after a capture
    send(1'b0, 4'd8);
    @(posedge clk); #3;
    n_rst = 1'b0;
    #1;
    chk("reset_async", {1'b0, an, seg}, {1'b0, AX, SX});
    @(negedge clk);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    expect3(7'h40, 7'h40, 7'h40, "post_reset");
    drain("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
